add_arbiter: RTL and testbench

- Shares one rca_add instance (N-bit adder, no carry-in, signed-overflow flag) among NREQ requesters.
- Requesters issue add or subtract jobs over valid/ready handshakes. Arbitration is round-robin.
- Subtract runs as two sequenced passes through the same adder: first negate b (~b + 1), then add to a.
- Results go out on one response channel with backpressure. The block sits between ALU clients and the shared adder datapath.

---
 rtl/add_arbiter.sv | 149 ++++++++++++++
 tb/tb_add_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// Round-robin arbiter that shares one adder among NREQ requesters.
// A subtract takes two passes through the adder: negate b, then add it to a.

module rca_add #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);
  assign sum = a + b;
  assign ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
endmodule

// state | meaning
// IDLE  | no job held; combinational round-robin grant on req_ready
// NEG   | subtract first pass: b_reg <= ~b_reg + 1
// ADD   | a_reg + b_reg; latch result into rsp_*
// RESP  | rsp_valid held until rsp_ready
module add_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_ovf,
  output logic              busy,
  output logic [CNTW-1:0]   done_cnt
);

  typedef enum logic [1:0] {IDLE, NEG, ADD, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic           b_sign;
  logic           op_reg;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           sel_op;

  logic [N-1:0]   add_x;
  logic [N-1:0]   add_y;
  logic [N-1:0]   add_sum;
  logic           add_ovf;
  logic           sub_ovf;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Gated by rst_n so req_ready reads as zero while reset is held.
  assign req_ready = (rst_n && state == IDLE && gnt_any) ? (NREQ'(1) << gnt_idx) : '0;

  assign sel_a  = req_a[int'(gnt_idx)*N +: N];
  assign sel_b  = req_b[int'(gnt_idx)*N +: N];
  assign sel_op = req_op[gnt_idx];

  assign add_x = (state == NEG) ? ~b_reg : a_reg;
  assign add_y = (state == NEG) ? N'(1) : b_reg;

  rca_add #(.N(N)) u_add (
    .a   (add_x),
    .b   (add_y),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // The original sign of b is kept apart so negating the most-negative value cannot corrupt it.
  assign sub_ovf = (a_reg[N-1] != b_sign) && (add_sum[N-1] != a_reg[N-1]);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      b_sign    <= 1'b0;
      op_reg    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_ovf   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_reg  <= sel_a;
            b_reg  <= sel_b;
            b_sign <= sel_b[N-1];
            op_reg <= sel_op;
            rsp_id <= gnt_idx;
            rr     <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
            state  <= sel_op ? NEG : ADD;
          end
        end
        NEG: begin
          b_reg <= add_sum;
          state <= ADD;
        end
        ADD: begin
          rsp_sum   <= add_sum;
          rsp_ovf   <= op_reg ? sub_ovf : add_ovf;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: arithmetic vectors, round-robin order,
// response backpressure and reset in the middle of a subtract.

module tb_add_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_ovf;
  logic              busy;
  logic [CNTW-1:0]   done_cnt;

  int n_cmp;
  int n_err;
  int exp_done;

  add_arbiter #(.N(N), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_done = 0;
  endtask

  // Called at a negedge; runs one job from requester id with rsp_ready high.
  task automatic do_job(input int id, input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_sum, input logic exp_ovf);
    int n;
    int lat;
    logic [NREQ-1:0] onehot;
    req_op[id]          = op;
    req_a[id*N +: N]    = a;
    req_b[id*N +: N]    = b;
    req_valid[id]       = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    onehot = '0;
    onehot[id] = 1'b1;
    chk("grant", req_ready, onehot);
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, op ? 3 : 2);
    chk("rsp_sum", rsp_sum, exp_sum);
    chk("rsp_ovf", rsp_ovf, exp_ovf);
    chk("rsp_id", rsp_id, id);
    chk("busy_resp", busy, 1);
    exp_done++;
    @(negedge clk);
    chk("rsp_valid_clr", rsp_valid, 0);
    chk("done_cnt", done_cnt, exp_done);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int ngrant;
    int idx;
    int n;
    int q_id[$];
    int exp_id;

    n_cmp    = 0;
    n_err    = 0;
    exp_done = 0;
    rst_n    = 1'b0;
    req_valid = '0;
    req_op   = '0;
    req_a    = '0;
    req_b    = '0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    do_reset();

    // arithmetic vectors
    do_job(0, 1'b0, 32'd32,        32'd61,        32'd93,        1'b0);
    do_job(1, 1'b1, 32'd5,         32'd100,       32'hFFFFFFA1,  1'b0);
    do_job(2, 1'b0, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b1);
    do_job(3, 1'b0, 32'hFFFFFFFF,  32'd122,       32'd121,       1'b0);
    do_job(0, 1'b1, 32'd0,         32'h80000000,  32'h80000000,  1'b1);
    do_job(1, 1'b1, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b1);
    do_job(2, 1'b1, 32'd10,        32'd3,         32'd7,         1'b0);
    do_job(3, 1'b0, 32'h80000000,  32'h80000000,  32'd0,         1'b1);

    // round-robin with all requesters valid from reset
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i]       = 1'b0;
      req_a[i*N +: N] = 32'(i * 10);
      req_b[i*N +: N] = 32'd1;
    end
    req_valid = '1;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_done = 0;
    ngrant   = 0;
    n        = 0;
    while (ngrant < 5 && n < 60) begin
      #1;
      chk("ready_onehot0", $onehot0(req_ready), 1);
      if (rsp_valid) begin
        exp_id = (q_id.size() > 0) ? q_id.pop_front() : -1;
        chk("rr_rsp_id", rsp_id, exp_id);
        chk("rr_rsp_sum", rsp_sum, exp_id * 10 + 1);
      end
      if (req_ready != '0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        chk("rr_order", idx, ngrant % NREQ);
        q_id.push_back(idx);
        ngrant++;
      end
      @(negedge clk);
      n++;
    end
    chk("rr_grants", ngrant, 5);
    req_valid = '0;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    do_reset();

    // backpressure: rsp_ready low for 10 cycles in RESP
    rsp_ready          = 1'b0;
    req_op[1]          = 1'b0;
    req_a[1*N +: N]    = 32'd7;
    req_b[1*N +: N]    = 32'd8;
    req_valid[1]       = 1'b1;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1]    = 1'b0;
    req_op[0]       = 1'b0;
    req_a[0*N +: N] = 32'd1;
    req_b[0*N +: N] = 32'd1;
    req_valid[0]    = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_sum", rsp_sum, 32'd15);
      chk("bp_rsp_id", rsp_id, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_done_cnt", done_cnt, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle", req_ready, 0);
    @(negedge clk);
    chk("bp_rsp_valid_clr", rsp_valid, 0);
    chk("bp_done_inc", done_cnt, 1);
    chk("bp_next_grant", req_ready, 4'b0001);
    req_valid[0] = 1'b0;
    #1;
    chk("bp_drop_regrant", req_ready, 0);
    @(negedge clk);
    chk("bp_not_accepted", busy, 0);
    do_reset();

    // reset during NEG of a subtract
    req_op[1]       = 1'b1;
    req_a[1*N +: N] = 32'd50;
    req_b[1*N +: N] = 32'd20;
    req_valid[1]    = 1'b1;
    #1;
    chk("rn_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1]    = 1'b0;
    req_op[2]       = 1'b0;
    req_a[2*N +: N] = 32'd3;
    req_b[2*N +: N] = 32'd4;
    req_valid[2]    = 1'b1;
    #1;
    chk("rn_busy_neg", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rn_busy", busy, 0);
    chk("rn_rsp_valid", rsp_valid, 0);
    chk("rn_req_ready", req_ready, 0);
    chk("rn_done_cnt", done_cnt, 0);
    chk("rn_rsp_sum", rsp_sum, 0);
    chk("rn_rsp_id", rsp_id, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rn_no_rsp", rsp_valid, 0);
    end
    rst_n    = 1'b1;
    exp_done = 0;
    do_job(2, 1'b0, 32'd3, 32'd4, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
